// File: rtl/expr_chk_sched.sv
// Round-robin front end that lends one expression-checker datapath to two
// byte-stream requesters, one whole expression at a time.
module expr_chk_sched #(
    parameter int unsigned MAX_LEN = 255,
    parameter int unsigned LEN_W   = 8,
    parameter logic [7:0]  TERM    = 8'h3B
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    output logic             chk_clr,
    output logic             chk_en,
    output logic [7:0]       chk_in,
    input  logic             chk_out,
    output logic             res_valid,
    output logic             res_pass,
    output logic             res_ovf,
    output logic             res_id,
    output logic [LEN_W-1:0] res_len,
    output logic             busy
);

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        REPORT,
        DRAIN
    } state_t;

    state_t           state;
    logic             grant;
    logic             last_grant;
    logic [LEN_W-1:0] len;
    logic             ovf;

    logic             accepting;
    logic             hs_valid;
    logic [7:0]       hs_data;
    logic             hs_term;

    // Only the granted requester ever sees ready, and only while chars are wanted.
    assign accepting  = (state == FEED) || (state == DRAIN);
    assign req0_ready = accepting && !grant;
    assign req1_ready = accepting && grant;
    assign hs_valid   = grant ? req1_valid : req0_valid;
    assign hs_data    = grant ? req1_data : req0_data;
    assign hs_term    = (hs_data == TERM);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            len        <= '0;
            ovf        <= 1'b0;
            chk_clr    <= 1'b0;
            chk_en     <= 1'b0;
            chk_in     <= '0;
            res_valid  <= 1'b0;
            res_pass   <= 1'b0;
            res_ovf    <= 1'b0;
            res_id     <= 1'b0;
            res_len    <= '0;
        end else begin
            chk_clr   <= 1'b1;
            chk_en    <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant   <= (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                        chk_clr <= 1'b0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    len   <= '0;
                    ovf   <= 1'b0;
                    state <= FEED;
                end
                FEED: begin
                    if (hs_valid) begin
                        if (hs_term) begin
                            // An empty expression has no verdict worth waiting for.
                            if (len == '0) begin
                                res_valid <= 1'b1;
                                res_pass  <= 1'b0;
                                res_ovf   <= 1'b0;
                                res_id    <= grant;
                                res_len   <= len;
                                state     <= REPORT;
                            end else begin
                                state <= WAIT;
                            end
                        end else if (len == MAX_LEN_W) begin
                            ovf   <= 1'b1;
                            state <= DRAIN;
                        end else begin
                            chk_en <= 1'b1;
                            chk_in <= hs_data;
                            len    <= len + LEN_W'(1);
                        end
                    end
                end
                WAIT: begin
                    // The last forwarded char has been consumed, so chk_out is final.
                    res_valid <= 1'b1;
                    res_pass  <= chk_out & ~ovf & (len != '0);
                    res_ovf   <= ovf;
                    res_id    <= grant;
                    res_len   <= len;
                    state     <= REPORT;
                end
                DRAIN: begin
                    if (hs_valid && hs_term) begin
                        res_valid <= 1'b1;
                        res_pass  <= 1'b0;
                        res_ovf   <= ovf;
                        res_id    <= grant;
                        res_len   <= len;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
